tile_map_render: RTL
====================

// Module: tile_map_render
// PURPOSE
//   Parametrised tile-map renderer; successor to the fixed 16x16 / 64-px map drawer.
//   Sits between the VGA timing generator and the sprite/overlay stages.
//   Generates tile-memory addresses, absorbs configurable memory read latency, and maps
//   tile codes through a runtime-writable 16-entry palette.
//   Adds frame-based blinking of the explosion tile and passes VGA timing through aligned.
// PARAMETERS
//   TILE_LOG2   6     log2 of tile edge in pixels
//   MAP_W_LOG2  4     log2 of map width in tiles
//   MAP_H_LOG2  4     log2 of map height in tiles
//   ORIGIN_X    448   hcount of left map edge
//   ORIGIN_Y    28    vcount of top map edge
//   MEM_LAT     1     tile-memory read latency in cycles, o_addr to i_data (1..4)
//   BLINK_LOG2  4     explosion blink half-period = 2^BLINK_LOG2 frames
//   H_LAST      1919  last active hcount
//   V_LAST      1079  last active vcount
// PORTS
//   i_pclk      in   1    pixel clock
//   i_rst_n     in   1    asynchronous active-low reset
//   i_hcount    in   12   | i_hsync in 1 | i_hblnk in 1   horizontal timing
//   i_vcount    in   12   | i_vsync in 1 | i_vblnk in 1   vertical timing
//   i_data      in   4    tile code from tile memory, valid MEM_LAT cycles after o_addr
//   i_pal_we    in   1    palette write strobe
//   i_pal_addr  in   4    palette index to write
//   i_pal_data  in   12   palette RGB444 value
//   o_addr      out  MAP_H_LOG2+MAP_W_LOG2  tile address {row, col}, registered
//   o_hcount/o_hsync/o_hblnk/o_vcount/o_vsync/o_vblnk  out  12/1/1/12/1/1  timing delayed by L
//   o_rgb       out  12   pixel colour, registered
// BEHAVIOUR
//   Clock and reset: one clock, i_pclk; reset is asynchronous, active-low on i_rst_n.
//   Reset: all outputs 0; frame counter 0; palette loads defaults
//     0:260 1:fec 2:03c 3:600 4:333 5:f73 6..15:000.
//   Latency L = MEM_LAT+2: stage A registers o_addr and the in-map flag; MEM_LAT stages
//     are memory wait; the final stage registers o_rgb. All timing outputs are delayed by
//     exactly L cycles.
//   In-map: ORIGIN_X <= h < ORIGIN_X+2^(TILE_LOG2+MAP_W_LOG2), same for v/ORIGIN_Y.
//   Address: col = (h-ORIGIN_X)>>TILE_LOG2, row = (v-ORIGIN_Y)>>TILE_LOG2, truncated
//     to field widths. o_addr is 0 when outside the map (no wrap-around aliasing).
//   Colour priority at output stage, using delayed signals:
//     hblnk|vblnk -> 000; v==0 -> ff0; v==V_LAST -> f00; h==0 -> 0f0; h==H_LAST -> 00f;
//     in-map -> palette[i_data]; else 555.
//   Blink: frame counter increments on each rising edge of i_vsync (edge-detect register).
//     When counter bit BLINK_LOG2 is 1 and code==5, output palette[4] instead of palette[5].
//     The counter wraps freely.
//   Palette write: entry updates on the clock edge with i_pal_we=1. A pixel reading the
//     same entry in that cycle gets the old value; the new value applies from the next cycle.
//   Reset mid-frame: pipeline flushes to 0. Output is valid again L cycles after release.
// CONFIGURATION
//   TILE_GRID_EN defined: in-map pixels whose tile-local x or y offset == 0 output fff
//     (grid lines). Priority is below the screen edges and above the palette.
//   Not defined: no grid logic; map pixels always come from the palette/blink path.
// STRUCTURE
//   Package tile_map_pkg: RGB444 colour constants (edges, 555 background), tile-code
//     localparams (SURROUND=0, PATH=1, OBST1=2, OBST2=3, BOMB=4, EXPL=5), default palette.
//   Sub-module tile_palette: 16x12 register file with async reset-to-defaults,
//     1 write port, 1 combinational read port.
//   Timing delay is an inline shift register of depth L inside this module.
// TESTING
//   1 Reset release, MEM_LAT=1, h=448,v=28, mem returns 1 -> o_addr=0x00 at cycle 1;
//     o_rgb=fec, o_hcount=448 at cycle 3.
//   2 h=1471,v=1051 -> o_addr=0xFF; h=1472 -> o_addr=0, o_rgb=555 after L.
//   3 v=0 any h -> ff0; h=0,v=500 -> 0f0; v=1079 -> f00; blank asserted -> 000.
//   4 Write pal[1]=abc in the same cycle the code-1 pixel is at the output stage
//     -> that pixel fec, next code-1 pixel abc.
//   5 Code 5 held over 32 vsync rising edges, BLINK_LOG2=4 -> f73 for frames 0-15,
//     333 for frames 16-31.
//   6 MEM_LAT=3 with TILE_GRID_EN -> L=5, all timing aligned; h=512,v=100 -> fff.

Source files
------------

// File: rtl/tile_map_pkg.sv
// Shared definitions for the tile-map renderer: colour constants, tile codes,
// the VGA timing bundle and the power-on palette contents.
package tile_map_pkg;

    typedef logic [11:0] rgb_t;

    typedef struct packed {
        logic [11:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [11:0] vcount;
        logic        vsync;
        logic        vblnk;
    } vga_timing_t;

    localparam rgb_t RGB_BLANK  = 12'h000;
    localparam rgb_t RGB_TOP    = 12'hff0;
    localparam rgb_t RGB_BOTTOM = 12'hf00;
    localparam rgb_t RGB_LEFT   = 12'h0f0;
    localparam rgb_t RGB_RIGHT  = 12'h00f;
    localparam rgb_t RGB_BG     = 12'h555;
    localparam rgb_t RGB_GRID   = 12'hfff;

    localparam logic [3:0] SURROUND = 4'd0;
    localparam logic [3:0] PATH     = 4'd1;
    localparam logic [3:0] OBST1    = 4'd2;
    localparam logic [3:0] OBST2    = 4'd3;
    localparam logic [3:0] BOMB     = 4'd4;
    localparam logic [3:0] EXPL     = 4'd5;

    function automatic rgb_t default_pal(input logic [3:0] idx);
        case (idx)
            SURROUND: return 12'h260;
            PATH:     return 12'hfec;
            OBST1:    return 12'h03c;
            OBST2:    return 12'h600;
            BOMB:     return 12'h333;
            EXPL:     return 12'hf73;
            default:  return 12'h000;
        endcase
    endfunction

endpackage

// File: rtl/tile_map_render_if.sv
// VGA timing bus (counters, syncs, blanks) passed between display pipeline stages.
interface tile_map_render_if;
    logic [11:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] vcount;
    logic        vsync;
    logic        vblnk;

    modport master (output hcount, hsync, hblnk, vcount, vsync, vblnk);
    modport slave  (input  hcount, hsync, hblnk, vcount, vsync, vblnk);
endinterface

// File: rtl/tile_palette.sv
// 16-entry RGB444 palette: one synchronous write port, one combinational read port,
// asynchronously reset to the default tile colours.
module tile_palette
    import tile_map_pkg::*;
(
    input  logic       i_pclk,
    input  logic       i_rst_n,
    input  logic       i_we,
    input  logic [3:0] i_waddr,
    input  rgb_t       i_wdata,
    input  logic [3:0] i_raddr,
    output rgb_t       o_rdata
);

    rgb_t entries [16];

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 16; i++) begin
                entries[i] <= default_pal(4'(i));
            end
        end else if (i_we) begin
            entries[i_waddr] <= i_wdata;
        end
    end

    // A read in the write cycle sees the old entry; the update lands on the edge.
    assign o_rdata = entries[i_raddr];

endmodule

// File: rtl/tile_map_render.sv
// Tile-map renderer: tile address generation, memory-latency alignment, palette
// lookup with explosion blinking. Optional grid overlay under `TILE_GRID_EN.
module tile_map_render
    import tile_map_pkg::*;
#(
    parameter int TILE_LOG2  = 6,
    parameter int MAP_W_LOG2 = 4,
    parameter int MAP_H_LOG2 = 4,
    parameter int ORIGIN_X   = 448,
    parameter int ORIGIN_Y   = 28,
    parameter int MEM_LAT    = 1,
    parameter int BLINK_LOG2 = 4,
    parameter int H_LAST     = 1919,
    parameter int V_LAST     = 1079
) (
    input  logic                               i_pclk,
    input  logic                               i_rst_n,
    tile_map_render_if.slave                   vga_in,
    tile_map_render_if.master                  vga_out,
    input  logic [3:0]                         i_data,
    input  logic                               i_pal_we,
    input  logic [3:0]                         i_pal_addr,
    input  logic [11:0]                        i_pal_data,
    output logic [MAP_H_LOG2+MAP_W_LOG2-1:0]   o_addr,
    output logic [11:0]                        o_rgb
);

    localparam int L       = MEM_LAT + 2;
    localparam int DLY     = L - 1;
    localparam int X_END   = ORIGIN_X + (1 << (TILE_LOG2 + MAP_W_LOG2));
    localparam int Y_END   = ORIGIN_Y + (1 << (TILE_LOG2 + MAP_H_LOG2));
    localparam int FRAME_W = BLINK_LOG2 + 1;

    vga_timing_t           tim_a;
    logic                  in_map_a;
    logic [MAP_W_LOG2-1:0] col_a;
    logic [MAP_H_LOG2-1:0] row_a;

    always_comb begin
        tim_a.hcount = vga_in.hcount;
        tim_a.hsync  = vga_in.hsync;
        tim_a.hblnk  = vga_in.hblnk;
        tim_a.vcount = vga_in.vcount;
        tim_a.vsync  = vga_in.vsync;
        tim_a.vblnk  = vga_in.vblnk;
    end

    assign in_map_a = (int'(vga_in.hcount) >= ORIGIN_X) && (int'(vga_in.hcount) < X_END) &&
                      (int'(vga_in.vcount) >= ORIGIN_Y) && (int'(vga_in.vcount) < Y_END);
    assign col_a    = MAP_W_LOG2'((vga_in.hcount - 12'(ORIGIN_X)) >> TILE_LOG2);
    assign row_a    = MAP_H_LOG2'((vga_in.vcount - 12'(ORIGIN_Y)) >> TILE_LOG2);

`ifdef TILE_GRID_EN
    localparam logic [11:0] TILE_MASK = 12'((1 << TILE_LOG2) - 1);
    logic grid_a;
    logic grid_p [DLY];
    assign grid_a = (((vga_in.hcount - 12'(ORIGIN_X)) & TILE_MASK) == 12'd0) ||
                    (((vga_in.vcount - 12'(ORIGIN_Y)) & TILE_MASK) == 12'd0);
`endif

    vga_timing_t tim_p    [DLY];
    logic        in_map_p [DLY];

    // Stage A registers the address; the remaining DLY-1 slots cover memory latency.
    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_addr <= '0;
            for (int i = 0; i < DLY; i++) begin
                tim_p[i]    <= '0;
                in_map_p[i] <= 1'b0;
`ifdef TILE_GRID_EN
                grid_p[i]   <= 1'b0;
`endif
            end
        end else begin
            o_addr      <= in_map_a ? {row_a, col_a} : '0;
            tim_p[0]    <= tim_a;
            in_map_p[0] <= in_map_a;
`ifdef TILE_GRID_EN
            grid_p[0]   <= grid_a;
`endif
            for (int i = 1; i < DLY; i++) begin
                tim_p[i]    <= tim_p[i-1];
                in_map_p[i] <= in_map_p[i-1];
`ifdef TILE_GRID_EN
                grid_p[i]   <= grid_p[i-1];
`endif
            end
        end
    end

    logic               vsync_q;
    logic [FRAME_W-1:0] frame_cnt;

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vsync_q   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vsync_q <= vga_in.vsync;
            if (vga_in.vsync && !vsync_q) begin
                frame_cnt <= frame_cnt + FRAME_W'(1);
            end
        end
    end

    vga_timing_t tim_o;
    logic        in_map_o;
    logic [3:0]  pal_idx;
    rgb_t        pal_rgb;
    rgb_t        rgb_d;

    assign tim_o    = tim_p[DLY-1];
    assign in_map_o = in_map_p[DLY-1];
    assign pal_idx  = (i_data == EXPL && frame_cnt[BLINK_LOG2]) ? BOMB : i_data;

    tile_palette u_palette (
        .i_pclk  (i_pclk),
        .i_rst_n (i_rst_n),
        .i_we    (i_pal_we),
        .i_waddr (i_pal_addr),
        .i_wdata (i_pal_data),
        .i_raddr (pal_idx),
        .o_rdata (pal_rgb)
    );

    always_comb begin
        rgb_d = RGB_BG;
        if (tim_o.hblnk || tim_o.vblnk)               rgb_d = RGB_BLANK;
        else if (tim_o.vcount == 12'd0)               rgb_d = RGB_TOP;
        else if (tim_o.vcount == 12'(V_LAST))         rgb_d = RGB_BOTTOM;
        else if (tim_o.hcount == 12'd0)               rgb_d = RGB_LEFT;
        else if (tim_o.hcount == 12'(H_LAST))         rgb_d = RGB_RIGHT;
`ifdef TILE_GRID_EN
        else if (in_map_o && grid_p[DLY-1])           rgb_d = RGB_GRID;
`endif
        else if (in_map_o)                            rgb_d = pal_rgb;
    end

    // Output stage: colour and timing leave together, L cycles after input.
    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rgb          <= '0;
            vga_out.hcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vcount <= '0;
            vga_out.vsync  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
        end else begin
            o_rgb          <= rgb_d;
            vga_out.hcount <= tim_o.hcount;
            vga_out.hsync  <= tim_o.hsync;
            vga_out.hblnk  <= tim_o.hblnk;
            vga_out.vcount <= tim_o.vcount;
            vga_out.vsync  <= tim_o.vsync;
            vga_out.vblnk  <= tim_o.vblnk;
        end
    end

endmodule
